// File: rtl/control_pipeline.sv
// Carries ID-decoded control bits through the ID/EX, EX/MEM and MEM/WB registers,
// inserting a load-use bubble and squashing younger instructions on a taken branch.
module control_pipeline #(
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_RegDst,
  input  logic [1:0]               i_ALUOp,
  input  logic                     i_ALUSrc,
  input  logic                     i_Branch,
  input  logic                     i_MemRead,
  input  logic                     i_MemWrite,
  input  logic                     i_RegWrite,
  input  logic                     i_MemtoReg,
  input  logic [REG_ADDR_BITS-1:0] i_rs,
  input  logic [REG_ADDR_BITS-1:0] i_rt,
  input  logic                     i_flush,
  output logic                     o_stall,
  output logic                     o_ex_RegDst,
  output logic [1:0]               o_ex_ALUOp,
  output logic                     o_ex_ALUSrc,
  output logic                     o_mem_Branch,
  output logic                     o_mem_MemRead,
  output logic                     o_mem_MemWrite,
  output logic                     o_wb_RegWrite,
  output logic                     o_wb_MemtoReg
);

  logic                     ex_Branch;
  logic                     ex_MemRead;
  logic                     ex_MemWrite;
  logic                     ex_RegWrite;
  logic                     ex_MemtoReg;
  logic [REG_ADDR_BITS-1:0] ex_rt;
  logic                     mem_RegWrite;
  logic                     mem_MemtoReg;
  logic                     rt_match;

  // A load targeting $zero never produces a real dependency.
  assign rt_match = (ex_rt != '0) && ((ex_rt == i_rs) || (ex_rt == i_rt));
  assign o_stall  = ex_MemRead && rt_match && !i_flush;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_ex_RegDst <= 1'b0;
      o_ex_ALUOp  <= 2'b00;
      o_ex_ALUSrc <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_rt       <= '0;
    end else if (i_enable) begin
      if (i_flush || o_stall) begin
        o_ex_RegDst <= 1'b0;
        o_ex_ALUOp  <= 2'b00;
        o_ex_ALUSrc <= 1'b0;
        ex_Branch   <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_RegWrite <= 1'b0;
        ex_MemtoReg <= 1'b0;
        ex_rt       <= '0;
      end else begin
        o_ex_RegDst <= i_RegDst;
        o_ex_ALUOp  <= i_ALUOp;
        o_ex_ALUSrc <= i_ALUSrc;
        ex_Branch   <= i_Branch;
        ex_MemRead  <= i_MemRead;
        ex_MemWrite <= i_MemWrite;
        ex_RegWrite <= i_RegWrite;
        ex_MemtoReg <= i_MemtoReg;
        ex_rt       <= i_rt;
      end
    end
  end

  // The instruction in EX is younger than the resolving branch, so it is squashed too.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_mem_Branch   <= 1'b0;
      o_mem_MemRead  <= 1'b0;
      o_mem_MemWrite <= 1'b0;
      mem_RegWrite   <= 1'b0;
      mem_MemtoReg   <= 1'b0;
    end else if (i_enable) begin
      if (i_flush) begin
        o_mem_Branch   <= 1'b0;
        o_mem_MemRead  <= 1'b0;
        o_mem_MemWrite <= 1'b0;
        mem_RegWrite   <= 1'b0;
        mem_MemtoReg   <= 1'b0;
      end else begin
        o_mem_Branch   <= ex_Branch;
        o_mem_MemRead  <= ex_MemRead;
        o_mem_MemWrite <= ex_MemWrite;
        mem_RegWrite   <= ex_RegWrite;
        mem_MemtoReg   <= ex_MemtoReg;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_wb_RegWrite <= 1'b0;
      o_wb_MemtoReg <= 1'b0;
    end else if (i_enable) begin
      o_wb_RegWrite <= mem_RegWrite;
      o_wb_MemtoReg <= mem_MemtoReg;
    end
  end

endmodule

// File: tb/tb_control_pipeline.sv
// Directed testbench for control_pipeline: hand-computed stage contents checked
// with immediate assertions after each step.
module tb_control_pipeline;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [8:0] id_bundle;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       flush;
  logic       stall;
  logic       ex_RegDst;
  logic [1:0] ex_ALUOp;
  logic       ex_ALUSrc;
  logic       mem_Branch;
  logic       mem_MemRead;
  logic       mem_MemWrite;
  logic       wb_RegWrite;
  logic       wb_MemtoReg;

  int errors = 0;
  int checks = 0;

  // Bundle layout: {RegDst, ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
  localparam logic [8:0] NOP = 9'b0_00_0_0_0_0_0_0;
  localparam logic [8:0] R   = 9'b1_10_0_0_0_0_1_0;
  localparam logic [8:0] LW  = 9'b0_00_1_0_1_0_1_1;
  localparam logic [8:0] SW  = 9'b0_00_1_0_0_1_0_0;
  localparam logic [8:0] BEQ = 9'b0_01_0_1_0_0_0_0;

  control_pipeline #(.REG_ADDR_BITS(5)) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_RegDst      (id_bundle[8]),
    .i_ALUOp       (id_bundle[7:6]),
    .i_ALUSrc      (id_bundle[5]),
    .i_Branch      (id_bundle[4]),
    .i_MemRead     (id_bundle[3]),
    .i_MemWrite    (id_bundle[2]),
    .i_RegWrite    (id_bundle[1]),
    .i_MemtoReg    (id_bundle[0]),
    .i_rs          (rs),
    .i_rt          (rt),
    .i_flush       (flush),
    .o_stall       (stall),
    .o_ex_RegDst   (ex_RegDst),
    .o_ex_ALUOp    (ex_ALUOp),
    .o_ex_ALUSrc   (ex_ALUSrc),
    .o_mem_Branch  (mem_Branch),
    .o_mem_MemRead (mem_MemRead),
    .o_mem_MemWrite(mem_MemWrite),
    .o_wb_RegWrite (wb_RegWrite),
    .o_wb_MemtoReg (wb_MemtoReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Visible output vector given which instruction bundle sits in EX, MEM and WB.
  function automatic logic [8:0] expect_out(input logic [8:0] ex_b, input logic [8:0] mem_b,
                                            input logic [8:0] wb_b);
    return {ex_b[8:5], mem_b[4:2], wb_b[1:0]};
  endfunction

  function automatic logic [8:0] observed();
    return {ex_RegDst, ex_ALUOp, ex_ALUSrc, mem_Branch, mem_MemRead, mem_MemWrite,
            wb_RegWrite, wb_MemtoReg};
  endfunction

  task automatic apply_stimulus(input logic [8:0] bundle, input logic [4:0] rs_v,
                                input logic [4:0] rt_v, input logic flush_v, input logic en_v);
    id_bundle = bundle;
    rs        = rs_v;
    rt        = rt_v;
    flush     = flush_v;
    enable    = en_v;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_stall(input string tag, input logic exp);
    checks++;
    assert (stall === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: stall got %b expected %b", tag, stall, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(NOP, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    step();
    reset = 1'b0;
    #1;
    check_output("after_reset", observed(), NOP);
    check_stall("after_reset_stall", 1'b0);

    // R-format latency through all three stages
    apply_stimulus(R, 5'd1, 5'd2, 1'b0, 1'b1);
    step();
    check_output("r_edge1", observed(), expect_out(R, NOP, NOP));
    apply_stimulus(NOP, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    check_output("r_edge2", observed(), expect_out(NOP, R, NOP));
    step();
    check_output("r_edge3", observed(), expect_out(NOP, NOP, R));
    step();
    check_output("r_edge4", observed(), NOP);

    // Load-use via rs: one bubble, then the held R bundle enters EX
    apply_stimulus(LW, 5'd1, 5'd5, 1'b0, 1'b1);
    check_stall("lw_in_id_no_stall", 1'b0);
    step();
    apply_stimulus(R, 5'd5, 5'd2, 1'b0, 1'b1);
    check_stall("loaduse_rs_stall", 1'b1);
    check_output("loaduse_pre", observed(), expect_out(LW, NOP, NOP));
    step();
    check_stall("loaduse_one_cycle", 1'b0);
    check_output("loaduse_bubble", observed(), expect_out(NOP, LW, NOP));
    step();
    apply_stimulus(NOP, 5'd0, 5'd0, 1'b0, 1'b1);
    check_output("loaduse_r_in_ex", observed(), expect_out(R, NOP, LW));
    step();
    check_output("loaduse_r_in_mem", observed(), expect_out(NOP, R, NOP));
    step();
    step();
    check_output("loaduse_drained", observed(), NOP);

    // Load to $zero never stalls
    apply_stimulus(LW, 5'd1, 5'd0, 1'b0, 1'b1);
    step();
    apply_stimulus(R, 5'd0, 5'd0, 1'b0, 1'b1);
    check_stall("lw_zero_no_stall", 1'b0);
    step();
    apply_stimulus(NOP, 5'd0, 5'd0, 1'b0, 1'b1);
    check_output("lw_zero_no_bubble", observed(), expect_out(R, LW, NOP));
    step();
    step();
    step();

    // Load-use via rt, and stall reflects held state while disabled
    apply_stimulus(LW, 5'd1, 5'd5, 1'b0, 1'b1);
    step();
    apply_stimulus(SW, 5'd0, 5'd5, 1'b0, 1'b0);
    check_stall("loaduse_rt_disabled", 1'b1);
    step();
    check_output("disabled_hold_lw", observed(), expect_out(LW, NOP, NOP));
    apply_stimulus(NOP, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    step();
    step();
    check_output("rt_case_drained", observed(), NOP);

    // Flush with BEQ in MEM, LW in EX, SW in ID with a load-use match
    apply_stimulus(BEQ, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    apply_stimulus(LW, 5'd1, 5'd7, 1'b0, 1'b1);
    step();
    apply_stimulus(SW, 5'd7, 5'd3, 1'b0, 1'b1);
    check_stall("flush_setup_stall", 1'b1);
    check_output("flush_setup", observed(), expect_out(LW, BEQ, NOP));
    apply_stimulus(SW, 5'd7, 5'd3, 1'b1, 1'b1);
    check_stall("flush_overrides_stall", 1'b0);
    step();
    apply_stimulus(NOP, 5'd0, 5'd0, 1'b0, 1'b1);
    check_output("flush_squash", observed(), expect_out(NOP, NOP, BEQ));
    step();

    // Flush with a register-writing instruction in MEM: MEM/WB must still advance
    apply_stimulus(R, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    apply_stimulus(SW, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    apply_stimulus(LW, 5'd0, 5'd4, 1'b1, 1'b1);
    step();
    apply_stimulus(NOP, 5'd0, 5'd0, 1'b0, 1'b1);
    check_output("flush_mem_retires", observed(), expect_out(NOP, NOP, R));
    step();

    // Asynchronous reset mid-stream with every stage occupied
    apply_stimulus(R, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    apply_stimulus(LW, 5'd0, 5'd3, 1'b0, 1'b1);
    step();
    apply_stimulus(SW, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    apply_stimulus(NOP, 5'd0, 5'd0, 1'b0, 1'b1);
    check_output("pre_reset_full", observed(), expect_out(SW, LW, R));
    #1;
    reset = 1'b1;
    #1;
    check_output("async_reset", observed(), NOP);
    step();
    reset = 1'b0;
    #1;
    step();
    check_output("post_reset_edge1", observed(), NOP);
    step();
    step();
    check_output("post_reset_edge3", observed(), NOP);

    // Disabled pipeline holds across changing inputs and flush, then resumes
    apply_stimulus(R, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    apply_stimulus(LW, 5'd1, 5'd2, 1'b1, 1'b0);
    step();
    check_output("hold_cycle1", observed(), expect_out(R, NOP, NOP));
    apply_stimulus(SW, 5'd3, 5'd4, 1'b1, 1'b0);
    step();
    check_output("hold_cycle2", observed(), expect_out(R, NOP, NOP));
    apply_stimulus(BEQ, 5'd6, 5'd7, 1'b1, 1'b0);
    step();
    check_output("hold_cycle3", observed(), expect_out(R, NOP, NOP));
    apply_stimulus(NOP, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    check_output("resume_mem", observed(), expect_out(NOP, R, NOP));
    step();
    check_output("resume_wb", observed(), expect_out(NOP, NOP, R));
    step();
    check_output("resume_drained", observed(), NOP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
